mult_div_unit: RTL

- Multi-cycle multiply/divide unit in the E stage of the P5 five-stage MIPS pipeline.
- Owns the architectural HI and LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Its HI/LO outputs feed the W-stage register-write-data selector for MFHI/MFLO.
- Its busy/start status feeds the hazard unit, which stalls any MD-class instruction in D.

---
 rtl/mult_div_unit_pkg.sv | 26 ++
 rtl/mult_div_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - operation codes and shared helpers for the multiply/divide unit
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEFAULT = 5;
    localparam int MD_DIV_CYCLES_DEFAULT  = 10;

    // Multi-cycle operations: the ones the hazard unit must see as "start".
    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset
//   start  in   qualifies md_op this cycle
//   md_op  in   [2:0] operation code (md_op_e)
//   A, B   in   [31:0] forwarded rs / rt operands
//   busy   out  multi-cycle operation in flight
//   HI, LO out  [31:0] architectural HI / LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi, pend_lo;
    logic             pend_wr;

    // Combinational result of the operation presented this cycle.
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      b_safe, a_mag, b_mag, uq, ur;
    logic [31:0]      res_hi, res_lo;
    logic             res_wr;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};

        // B==0 never writes back; substitute 1 so the divider stays defined.
        b_safe = (B == 32'd0) ? 32'd1 : B;
        a_mag  = A[31] ? (32'd0 - A) : A;
        b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        if (md_op == MD_DIV) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end else begin
            uq = A / b_safe;
            ur = A % b_safe;
        end

        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        case (md_op)
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            MD_DIV: begin
                // Magnitude divide then restore signs; 0x80000000 / -1 wraps to
                // quotient 0x80000000, remainder 0 without special handling.
                res_lo = (A[31] ^ B[31]) ? (32'd0 - uq) : uq;
                res_hi = A[31] ? (32'd0 - ur) : ur;
                res_wr = (B != 32'd0);
            end
            MD_DIVU: begin
                res_lo = uq;
                res_hi = ur;
                res_wr = (B != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (count != '0) begin
            // In flight: new starts are dropped, HI/LO land on the final edge.
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                pend_wr <= 1'b0;
                if (pend_wr) begin
                    hi_q <= pend_hi;
                    lo_q <= pend_lo;
                end
            end
        end else if (start) begin
            if (md_is_long(md_op)) begin
                count   <= md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end else if (md_op == MD_MTHI) begin
                hi_q <= A;
            end else if (md_op == MD_MTLO) begin
                lo_q <= A;
            end
        end
    end

    assign busy = (count != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
